// File: rtl/queue_drain_if.sv
// Handshake bundle for queue_drain: upstream queue read port plus the
// downstream valid/ready beat stream.
// Optional feature macro: QUEUE_DRAIN_STATS_EN adds drained_count.
interface queue_drain_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  enable;
    logic                  q_empty;
    logic [DATA_WIDTH-1:0] q_read_data;
    logic                  q_read_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
`ifdef QUEUE_DRAIN_STATS_EN
    logic [15:0]           drained_count;
`endif

    // The drain engine itself
    modport master (
        input  enable, q_empty, q_read_data, out_ready,
`ifdef QUEUE_DRAIN_STATS_EN
        output drained_count,
`endif
        output q_read_en, out_data, out_valid, out_last
    );

    // Queue + downstream consumer side
    modport slave (
        output enable, q_empty, q_read_data, out_ready,
`ifdef QUEUE_DRAIN_STATS_EN
        input  drained_count,
`endif
        input  q_read_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/queue_drain.sv
// queue_drain: pulls samples from a 1-cycle-latency upstream queue into a
// 2-entry skid buffer and presents them as a valid/ready stream framed in
// BURST_LEN-beat bursts (out_last on the final beat).
// Optional feature macro: QUEUE_DRAIN_STATS_EN adds a 16-bit pop counter.
module queue_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 8
) (
    input logic          sclk,
    input logic          reset,
    queue_drain_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t                state;
    logic [1:0]            buf_count;
    logic                  inflight;
    logic                  valid;
    logic [DATA_WIDTH-1:0] entry0;  // oldest, drives out_data directly
    logic [DATA_WIDTH-1:0] entry1;
    logic [7:0]            beat;
    logic                  pop;
    logic                  capture;
    logic                  rd;
    logic [2:0]            occ;
    logic [1:0]            count_next;

    assign pop     = valid & bus.out_ready;
    assign capture = inflight;

    // Occupancy as it will stand after this cycle's pop; a read may only go
    // out if its sample is guaranteed a slot when it lands next cycle.
    assign occ = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign rd  = ~reset & bus.enable & ~bus.q_empty & (occ < 3'd2);

    // Buffer occupancy after this edge's capture/pop pair
    always_comb begin
        count_next = buf_count;
        case ({capture, pop})
            2'b10:   count_next = buf_count + 2'd1;
            2'b01:   count_next = buf_count - 2'd1;
            default: count_next = buf_count;
        endcase
    end

    // Occupancy FSM: state, counters and registered valid track buffer fill
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            buf_count <= 2'd0;
            inflight  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            buf_count <= count_next;
            inflight  <= rd;
            valid     <= (count_next != 2'd0);
            if (count_next == 2'd2)
                state <= FULL;
            else if (count_next == 2'd1 || rd)
                state <= FETCH;
            else
                state <= IDLE;
        end
    end

    // In-order 2-entry storage; entry0 only changes on a pop or when the
    // buffer was empty, so out_data is stable while stalled.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
        end else if (pop) begin
            if (capture && buf_count == 2'd1)
                entry0 <= bus.q_read_data;
            else
                entry0 <= entry1;
            if (capture && state == FULL)
                entry1 <= bus.q_read_data;
        end else if (capture) begin
            if (buf_count == 2'd0)
                entry0 <= bus.q_read_data;
            else
                entry1 <= bus.q_read_data;
        end
    end

    // Beat position within the current frame, advanced per accepted beat
    always_ff @(posedge sclk or posedge reset) begin
        if (reset)
            beat <= 8'd0;
        else if (pop)
            beat <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
    end

`ifdef QUEUE_DRAIN_STATS_EN
    logic [15:0] drained;

    // Free-running count of delivered beats, wraps naturally at 16 bits
    always_ff @(posedge sclk or posedge reset) begin
        if (reset)
            drained <= 16'd0;
        else if (pop)
            drained <= drained + 16'd1;
    end

    assign bus.drained_count = drained;
`endif

    assign bus.q_read_en = rd;
    assign bus.out_valid = valid;
    assign bus.out_data  = entry0;
    assign bus.out_last  = valid & (beat == LAST_BEAT);
endmodule

// File: tb/tb_queue_drain.sv
// Directed bench for queue_drain: behavioural upstream queue with 1-cycle
// registered read data, a negedge beat monitor, and hand-computed checks.
module tb_queue_drain;
    logic sclk = 1'b0;
    logic reset = 1'b1;

    queue_drain_if #(.DATA_WIDTH(64)) bus ();

    queue_drain #(.DATA_WIDTH(64), .BURST_LEN(8)) dut (
        .sclk  (sclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    int n_chk = 0;
    int n_bad = 0;

    // upstream queue model
    logic [63:0] mem [0:63];
    int  wr_idx = 0;
    int  rd_idx = 0;
    int  rd_cnt = 0;
    int  rd_base = 0;
    bit  inf_mode = 1'b0;
    int  cyc = 0;
    int  pop_cnt = 0;

    logic [63:0] b_data [$];
    logic        b_last [$];
    int          b_cyc  [$];

    assign bus.q_empty = inf_mode ? 1'b0 : (rd_idx == wr_idx);

    always @(posedge sclk) begin
        cyc <= cyc + 1;
        if (bus.q_read_en) begin
            rd_cnt <= rd_cnt + 1;
            if (inf_mode)
                bus.q_read_data <= 64'(rd_cnt);
            else begin
                bus.q_read_data <= mem[rd_idx % 64];
                rd_idx <= rd_idx + 1;
            end
        end
    end

    always @(negedge sclk) begin
        if (bus.out_valid && bus.out_ready) begin
            pop_cnt++;
            if (!inf_mode) begin
                b_data.push_back(bus.out_data);
                b_last.push_back(bus.out_last);
                b_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic load(input logic [63:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_idx % 64] = first + 64'(i);
            wr_idx++;
        end
    endtask

    task automatic clear_log();
        b_data.delete();
        b_last.delete();
        b_cyc.delete();
        rd_base = rd_cnt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.out_ready = 1'b0;
        step(2);
        wr_idx = rd_idx;
        clear_log();
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (b_data.size() < n && k < budget) begin
            @(negedge sclk);
            #1;
            k++;
        end
        if (b_data.size() < n) chk("beat_timeout", 64'(b_data.size()), 64'(n));
        step(1);
    endtask

    initial begin
        bus.enable = 1'b1;
        bus.out_ready = 1'b1;
        bus.q_read_data = '0;
        load(64'h99, 1);
        step(2);
        // reset holds everything quiet even with data available
        chk("rst_valid", 64'(bus.out_valid), 0);
        chk("rst_last",  64'(bus.out_last), 0);
        chk("rst_data",  bus.out_data, 0);
        chk("rst_rden",  64'(bus.q_read_en), 0);

        // streaming burst, 10 beats to see frame wrap
        do_reset();
        load(64'h11, 10);
        bus.enable = 1'b1;
        bus.out_ready = 1'b1;
        reset = 1'b0;
        wait_beats(10, 40);
        chk("a_beats", 64'(b_data.size()), 10);
        chk("a_reads", 64'(rd_cnt - rd_base), 10);
        for (int i = 0; i < 10 && i < b_data.size(); i++) begin
            chk($sformatf("a_data%0d", i), b_data[i], 64'h11 + 64'(i));
            chk($sformatf("a_last%0d", i), 64'(b_last[i]), (i == 7) ? 64'd1 : 64'd0);
            chk($sformatf("a_cyc%0d", i), 64'(b_cyc[i] - b_cyc[0]), 64'(i));
        end

        // downstream stall: two reads fill the buffer, head held
        do_reset();
        load(64'h11, 8);
        bus.enable = 1'b1;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        step(5);
        chk("b_reads", 64'(rd_cnt - rd_base), 2);
        chk("b_valid", 64'(bus.out_valid), 1);
        chk("b_data",  bus.out_data, 64'h11);
        chk("b_rden",  64'(bus.q_read_en), 0);
        step(3);
        chk("b_hold",  bus.out_data, 64'h11);
        chk("b_reads2", 64'(rd_cnt - rd_base), 2);
        bus.out_ready = 1'b1;
        wait_beats(8, 40);
        for (int i = 0; i < 8 && i < b_data.size(); i++) begin
            chk($sformatf("b_out%0d", i), b_data[i], 64'h11 + 64'(i));
            chk($sformatf("b_last%0d", i), 64'(b_last[i]), (i == 7) ? 64'd1 : 64'd0);
        end

        // single sample then queue empty
        do_reset();
        load(64'h55, 1);
        bus.enable = 1'b1;
        bus.out_ready = 1'b1;
        reset = 1'b0;
        step(10);
        chk("c_reads", 64'(rd_cnt - rd_base), 1);
        chk("c_beats", 64'(b_data.size()), 1);
        if (b_data.size() > 0) chk("c_data", b_data[0], 64'h55);
        if (b_last.size() > 0) chk("c_last", 64'(b_last[0]), 0);
        chk("c_rden",  64'(bus.q_read_en), 0);
        chk("c_valid", 64'(bus.out_valid), 0);

        // enable drops with a read in flight
        do_reset();
        load(64'h21, 4);
        bus.enable = 1'b1;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        step(1);
        bus.enable = 1'b0;
        step(5);
        chk("d_reads", 64'(rd_cnt - rd_base), 1);
        chk("d_valid", 64'(bus.out_valid), 1);
        chk("d_data",  bus.out_data, 64'h21);
        chk("d_rden",  64'(bus.q_read_en), 0);
        bus.out_ready = 1'b1;
        step(3);
        chk("d_beats", 64'(b_data.size()), 1);
        if (b_data.size() > 0) chk("d_out", b_data[0], 64'h21);
        chk("d_reads2", 64'(rd_cnt - rd_base), 1);
        chk("d_valid2", 64'(bus.out_valid), 0);

        // reset mid-stream with 0x33 in flight: it is lost, 0x34 follows
        do_reset();
        load(64'h31, 8);
        bus.enable = 1'b1;
        bus.out_ready = 1'b1;
        reset = 1'b0;
        step(3);
        chk("e_reads", 64'(rd_cnt - rd_base), 3);
        reset = 1'b1;
        #1;
        chk("e_valid", 64'(bus.out_valid), 0);
        chk("e_rden",  64'(bus.q_read_en), 0);
        step(2);
        clear_log();
        reset = 1'b0;
        wait_beats(5, 30);
        step(3);
        chk("e_beats", 64'(b_data.size()), 5);
        if (b_data.size() > 0) chk("e_first", b_data[0], 64'h34);
        if (b_data.size() > 4) chk("e_tail", b_data[4], 64'h38);

`ifdef QUEUE_DRAIN_STATS_EN
        // pop counter wrap
        do_reset();
        chk("s_zero", 64'(bus.drained_count), 0);
        inf_mode = 1'b1;
        bus.enable = 1'b1;
        bus.out_ready = 1'b1;
        begin
            int base;
            int k;
            base = pop_cnt;
            k = 0;
            reset = 1'b0;
            while (pop_cnt - base < 65537 && k < 70000) begin
                @(negedge sclk);
                #1;
                k++;
            end
            @(posedge sclk);
            #1;
            bus.out_ready = 1'b0;
            bus.enable = 1'b0;
            step(2);
            chk("s_pops", 64'(pop_cnt - base), 65537);
            chk("s_count", 64'(bus.drained_count), 1);
        end
        inf_mode = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
